// File: rtl/plic_claim_ctrl.sv
// ---------------------------------------------------------------------------
// plic_claim_ctrl
//
// Per-target claim/complete sequencer for the PLIC. It sits between the
// target's priority resolver and the register-bus claim/complete interface.
// A claim read hands the resolver's winning ID to the hart and pulses the
// gateway so the source's pending bit is cleared. The block tracks which
// sources are in service and re-enables a source's gateway when a valid
// completion arrives. After a non-zero claim, EIP is masked and further
// claims are stalled for SETTLE_CYCLES cycles. This gives the resolver
// pipeline time to settle on the new pending state.
//
// Parameters
//   SOURCES        number of interrupt sources (source 0 means "none")
//   SOURCES_BITS   width of a source ID
//   SETTLE_CYCLES  EIP mask / claim stall length after a claim (1..15)
//
// Ports
//   clk_i           system clock
//   rst_i           synchronous active-high reset
//   ireq_i          registered interrupt request from the target resolver
//   id_i            registered winning ID from the target resolver
//   claim_req_i     claim read request, level, held until claim_ack_o
//   claim_ack_o     one-cycle claim acknowledge
//   claim_id_o      claimed ID, valid in the ack cycle, held until next ack
//   complete_i      one-cycle completion write strobe
//   complete_id_i   ID being completed
//   claim_o         one-hot pulse clearing the claimed source's pending bit
//   complete_o      one-hot pulse re-enabling the completed source's gateway
//   in_service_o    in-service mask (bit 0 always 0)
//   eip_o           external interrupt pending to the hart
//   complete_err_o  one-cycle pulse when a completion is ignored
// ---------------------------------------------------------------------------
module plic_claim_ctrl #(
  parameter int SOURCES       = 8,
  parameter int SOURCES_BITS  = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ireq_i,
  input  logic [SOURCES_BITS-1:0] id_i,
  input  logic                    claim_req_i,
  output logic                    claim_ack_o,
  output logic [SOURCES_BITS-1:0] claim_id_o,
  input  logic                    complete_i,
  input  logic [SOURCES_BITS-1:0] complete_id_i,
  output logic [SOURCES-1:0]      claim_o,
  output logic [SOURCES-1:0]      complete_o,
  output logic [SOURCES-1:0]      in_service_o,
  output logic                    eip_o,
  output logic                    complete_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Value loaded into the settle counter when a non-zero claim is acked.
  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [3:0]              settleCnt_q, settleCnt_d;
  logic [SOURCES_BITS-1:0] capId_q, capId_d;
  logic [SOURCES-1:0]      inService_q, inService_d;
  logic [SOURCES-1:0]      completePulse_q, completePulse_d;
  logic                    completeErr_q, completeErr_d;

  logic [SOURCES_BITS-1:0] effId;
  logic                    claimValid;
  logic                    completeValid;
  logic [SOURCES-1:0]      claimMask;
  logic [SOURCES-1:0]      completeMask;

  // Turns a source ID into a one-hot source mask.
  function automatic logic [SOURCES-1:0] idToMask(input logic [SOURCES_BITS-1:0] id);
    logic [SOURCES-1:0] mask;
    mask     = '0;
    mask[id] = 1'b1;
    return mask;
  endfunction

  // A request with no pending interrupt claims the reserved ID 0.
  assign effId = ireq_i ? id_i : '0;

  // The claim pulse comes only from registered state, so the gateway never
  // sees a combinational path from the bus. An ack of ID 0 does not claim
  // anything.
  assign claimValid = (state_q == ACK) && (capId_q != '0);
  assign claimMask  = claimValid ? idToMask(capId_q) : '0;

  // A completion is honoured only for a non-zero ID that is already in
  // service. The check reads the register before this cycle's claim update.
  // A completion of the ID being claimed in the same cycle is therefore
  // rejected.
  assign completeValid = complete_i && (complete_id_i != '0) && inService_q[complete_id_i];
  assign completeMask  = completeValid ? idToMask(complete_id_i) : '0;

  // Claim FSM next-state logic. In IDLE, a request captures the effective
  // ID. ACK lasts exactly one cycle. After a non-zero claim, the FSM spends
  // SETTLE_CYCLES-1 cycles in SETTLE. Together with the ACK cycle, this
  // masks EIP for SETTLE_CYCLES cycles. The counter is loaded with
  // SETTLE_CYCLES-1 and the FSM leaves SETTLE on the decrement that reaches
  // zero. If the load value is already zero (SETTLE_CYCLES=1), ACK returns
  // straight to IDLE.
  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    capId_d     = capId_q;
    unique case (state_q)
      IDLE: begin
        if (claim_req_i) begin
          capId_d = effId;
          state_d = ACK;
        end
      end
      ACK: begin
        if (capId_q != '0) begin
          settleCnt_d = SettleLoad;
          state_d     = (SettleLoad == 4'd0) ? IDLE : SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (settleCnt_q <= 4'd1) begin
          settleCnt_d = 4'd0;
          state_d     = IDLE;
        end else begin
          settleCnt_d = settleCnt_q - 4'd1;
        end
      end
      default: begin
        settleCnt_d = 4'd0;
        state_d     = IDLE;
      end
    endcase
  end

  // In-service and completion bookkeeping runs in every FSM state. When a
  // claim and a valid completion of different IDs coincide, both apply:
  // the claimed bit is set and the completed bit is cleared.
  always_comb begin
    inService_d     = (inService_q | claimMask) & ~completeMask;
    inService_d[0]  = 1'b0;
    completePulse_d = completeMask;
    completeErr_d   = complete_i && !completeValid;
  end

  // State and bookkeeping registers. Reset aborts any claim in flight.
  // Because the pulse outputs are register-derived, nothing is emitted
  // after the reset edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      settleCnt_q     <= 4'd0;
      capId_q         <= '0;
      inService_q     <= '0;
      completePulse_q <= '0;
      completeErr_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      settleCnt_q     <= settleCnt_d;
      capId_q         <= capId_d;
      inService_q     <= inService_d;
      completePulse_q <= completePulse_d;
      completeErr_q   <= completeErr_d;
    end
  end

  // EIP is masked while the FSM is claiming or settling. It is also forced
  // low while reset is held, even after the first reset edge has put the
  // FSM back in IDLE.
  assign eip_o          = ireq_i && (state_q == IDLE) && !rst_i;
  assign claim_ack_o    = (state_q == ACK);
  assign claim_id_o     = capId_q;
  assign claim_o        = claimMask;
  assign complete_o     = completePulse_q;
  assign in_service_o   = inService_q;
  assign complete_err_o = completeErr_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_plic_claim_ctrl
//
// Directed bench for plic_claim_ctrl (SOURCES=8, SETTLE_CYCLES=2). Each
// table row holds the inputs applied for one clock cycle. It also holds the
// outputs expected just after that cycle's rising edge, with the same inputs
// still applied. Two hand-written sequences follow the table: the ack spacing
// with a held request, and reset in the middle of an ACK cycle.
// ---------------------------------------------------------------------------
module tb_plic_claim_ctrl;

  localparam int SOURCES       = 8;
  localparam int SOURCES_BITS  = 3;
  localparam int SETTLE_CYCLES = 2;

  logic                    clk;
  logic                    rst;
  logic                    ireq;
  logic [SOURCES_BITS-1:0] id;
  logic                    claimReq;
  logic                    claimAck;
  logic [SOURCES_BITS-1:0] claimId;
  logic                    complete;
  logic [SOURCES_BITS-1:0] completeId;
  logic [SOURCES-1:0]      claimMask;
  logic [SOURCES-1:0]      completeMask;
  logic [SOURCES-1:0]      inService;
  logic                    eip;
  logic                    completeErr;

  int checks = 0;
  int errors = 0;

  plic_claim_ctrl #(
    .SOURCES      (SOURCES),
    .SOURCES_BITS (SOURCES_BITS),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ireq_i        (ireq),
    .id_i          (id),
    .claim_req_i   (claimReq),
    .claim_ack_o   (claimAck),
    .claim_id_o    (claimId),
    .complete_i    (complete),
    .complete_id_i (completeId),
    .claim_o       (claimMask),
    .complete_o    (completeMask),
    .in_service_o  (inService),
    .eip_o         (eip),
    .complete_err_o(completeErr)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ireq;
    logic [2:0] id;
    logic       creq;
    logic       cmp;
    logic [2:0] cid;
    logic       eAck;
    logic [2:0] eClaimId;
    logic [7:0] eClaim;
    logic [7:0] eComp;
    logic [7:0] eSvc;
    logic       eEip;
    logic       eErr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mv(input logic r, input logic iq, input logic [2:0] i,
                              input logic cr, input logic cm, input logic [2:0] ci,
                              input logic a, input logic [2:0] cIdExp,
                              input logic [7:0] cl, input logic [7:0] co,
                              input logic [7:0] sv, input logic e, input logic er);
    vec_t v;
    v.rst = r;  v.ireq = iq; v.id = i; v.creq = cr; v.cmp = cm; v.cid = ci;
    v.eAck = a; v.eClaimId = cIdExp; v.eClaim = cl; v.eComp = co;
    v.eSvc = sv; v.eEip = e; v.eErr = er;
    return v;
  endfunction

  // Drive one cycle of inputs, then let the rising edge pass and settle.
  task automatic applyStimulus(input logic r, input logic iq, input logic [2:0] i,
                               input logic cr, input logic cm, input logic [2:0] ci);
    rst        = r;
    ireq       = iq;
    id         = i;
    claimReq   = cr;
    complete   = cm;
    completeId = ci;
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if it does not hold.
  task automatic checkOutput(input string name, input int idx,
                             input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic checkAll(input vec_t v, input int idx);
    checkOutput("claim_ack",    idx, {7'd0, claimAck},    {7'd0, v.eAck});
    checkOutput("claim_id",     idx, {5'd0, claimId},     {5'd0, v.eClaimId});
    checkOutput("claim_o",      idx, claimMask,           v.eClaim);
    checkOutput("complete_o",   idx, completeMask,        v.eComp);
    checkOutput("in_service",   idx, inService,           v.eSvc);
    checkOutput("eip",          idx, {7'd0, eip},         {7'd0, v.eEip});
    checkOutput("complete_err", idx, {7'd0, completeErr}, {7'd0, v.eErr});
  endtask

  // Guard against a hang anywhere in the test.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    bit seen;

    // Columns: rst ireq id creq cmp cid | ack claimId claim_o complete_o in_service eip err
    // Reset held two cycles with a claim and a completion requested.
    vecs.push_back(mv(1,1,5,1,1,5, 0,0,8'h00,8'h00,8'h00,0,0));
    vecs.push_back(mv(1,1,5,1,1,5, 0,0,8'h00,8'h00,8'h00,0,0));
    // Basic claim of ID 5.
    vecs.push_back(mv(0,1,5,1,0,0, 1,5,8'h20,8'h00,8'h00,0,0));
    vecs.push_back(mv(0,1,5,0,0,0, 0,5,8'h00,8'h00,8'h20,0,0));
    vecs.push_back(mv(0,1,5,0,0,0, 0,5,8'h00,8'h00,8'h20,1,0));
    // Complete 5, complete 5 again, complete 0, idle.
    vecs.push_back(mv(0,0,0,0,1,5, 0,5,8'h00,8'h20,8'h00,0,0));
    vecs.push_back(mv(0,0,0,0,1,5, 0,5,8'h00,8'h00,8'h00,0,1));
    vecs.push_back(mv(0,0,0,0,1,0, 0,5,8'h00,8'h00,8'h00,0,1));
    vecs.push_back(mv(0,0,0,0,0,0, 0,5,8'h00,8'h00,8'h00,0,0));
    // Empty claim, back in IDLE next cycle, a new claim two cycles later.
    vecs.push_back(mv(0,0,0,1,0,0, 1,0,8'h00,8'h00,8'h00,0,0));
    vecs.push_back(mv(0,1,2,0,0,0, 0,0,8'h00,8'h00,8'h00,1,0));
    vecs.push_back(mv(0,0,0,1,0,0, 1,0,8'h00,8'h00,8'h00,0,0));
    vecs.push_back(mv(0,0,0,0,0,0, 0,0,8'h00,8'h00,8'h00,0,0));
    // Claim 3, then claim 6 with completion of 3 in claim 6's ACK cycle.
    vecs.push_back(mv(0,1,3,1,0,0, 1,3,8'h08,8'h00,8'h00,0,0));
    vecs.push_back(mv(0,1,6,0,0,0, 0,3,8'h00,8'h00,8'h08,0,0));
    vecs.push_back(mv(0,1,6,1,0,0, 0,3,8'h00,8'h00,8'h08,1,0));
    vecs.push_back(mv(0,1,6,1,0,0, 1,6,8'h40,8'h00,8'h08,0,0));
    vecs.push_back(mv(0,1,6,0,1,3, 0,6,8'h00,8'h08,8'h40,0,0));
    vecs.push_back(mv(0,1,6,0,0,0, 0,6,8'h00,8'h00,8'h40,1,0));
    // Complete 6, re-claim 6 and complete it in its own ACK cycle (rejected).
    vecs.push_back(mv(0,1,6,0,1,6, 0,6,8'h00,8'h40,8'h00,1,0));
    vecs.push_back(mv(0,1,6,1,0,0, 1,6,8'h40,8'h00,8'h00,0,0));
    vecs.push_back(mv(0,1,6,0,1,6, 0,6,8'h00,8'h00,8'h40,0,1));
    vecs.push_back(mv(0,1,6,0,0,0, 0,6,8'h00,8'h00,8'h40,1,0));
    // Request held through SETTLE: second ack only after returning to IDLE.
    vecs.push_back(mv(0,1,1,1,0,0, 1,1,8'h02,8'h00,8'h40,0,0));
    vecs.push_back(mv(0,1,4,1,0,0, 0,1,8'h00,8'h00,8'h42,0,0));
    vecs.push_back(mv(0,1,4,1,0,0, 0,1,8'h00,8'h00,8'h42,1,0));
    vecs.push_back(mv(0,1,4,1,0,0, 1,4,8'h10,8'h00,8'h42,0,0));
    // Reset in the middle of SETTLE.
    vecs.push_back(mv(0,1,4,0,0,0, 0,4,8'h00,8'h00,8'h52,0,0));
    vecs.push_back(mv(1,1,4,0,0,0, 0,0,8'h00,8'h00,8'h00,0,0));
    vecs.push_back(mv(0,1,4,0,0,0, 0,0,8'h00,8'h00,8'h00,1,0));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].ireq, vecs[k].id,
                    vecs[k].creq, vecs[k].cmp, vecs[k].cid);
      checkAll(vecs[k], k);
    end

    // Ack spacing with claim_req held high on ID 7: the first ack arrives
    // after one edge. The next one follows SETTLE_CYCLES+1 edges later.
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      applyStimulus(0, 1, 7, 1, 0, 0);
      if (claimAck) seen = 1;
    end
    checkOutput("first_ack_seen", 100, {7'd0, seen}, 8'd1);
    checkOutput("first_ack_id",   100, {5'd0, claimId}, 8'd7);
    gap  = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      applyStimulus(0, 1, 7, 1, 0, 0);
      gap++;
      if (claimAck) seen = 1;
    end
    checkOutput("second_ack_seen", 101, {7'd0, seen}, 8'd1);
    checkOutput("ack_gap",         101, 8'(gap), 8'(SETTLE_CYCLES + 1));
    checkOutput("claim_o_second",  101, claimMask, 8'h80);
    checkOutput("in_service_b7",   101, inService, 8'h80);

    // Reset edge during the ACK cycle, with a completion of 7 offered.
    // Nothing may pulse afterwards.
    applyStimulus(1, 1, 7, 0, 1, 7);
    checkAll(mv(1,1,7,0,1,7, 0,0,8'h00,8'h00,8'h00,0,0), 102);
    applyStimulus(0, 1, 7, 0, 0, 0);
    checkAll(mv(0,1,7,0,0,0, 0,0,8'h00,8'h00,8'h00,1,0), 103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
